// File: rtl/sng_pkg.sv
// Shared definitions for the stochastic-number stream generator: FSM state
// type, quota arithmetic, Weyl-sequence rank helpers and parameter checks.
package sng_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Greatest common divisor, used to confirm the Weyl step visits every position.
    function automatic int gcd(input int a, input int b);
        int x;
        int y;
        int r;
        x = (a < 0) ? -a : a;
        y = (b < 0) ? -b : b;
        while (y != 0) begin
            r = x % y;
            x = y;
            y = r;
        end
        return x;
    endfunction

    // Non-negative remainder of v modulo m.
    function automatic int mod_pos(input longint v, input int m);
        longint r;
        r = v % longint'(m);
        if (r < 0) begin
            r = r + longint'(m);
        end
        return int'(r);
    endfunction

    // Multiplicative inverse of a modulo m (0 when none exists or m == 1).
    function automatic int mod_inv(input int a, input int m);
        int r;
        int aa;
        r  = 0;
        aa = mod_pos(longint'(a), m);
        for (int i = 1; i < m; i++) begin
            if ((r == 0) && (mod_pos(longint'(aa) * longint'(i), m) == 1)) begin
                r = i;
            end
        end
        return r;
    endfunction

    // First Weyl position of channel c.
    function automatic int ch_start(input int c, input int base, input int step, input int t);
        return mod_pos(longint'(base) + longint'(c) * longint'(step), t);
    endfunction

    // Order in which position p is visited by the walk start, start+stride, ...
    function automatic int rank(input int p, input int start, input int stride, input int t);
        int d;
        d = mod_pos(longint'(p) - longint'(start), t);
        return mod_pos(longint'(d) * longint'(mod_inv(stride, t)), t);
    endfunction

    // Number of set bits for an offset-binary sample u: round(u*T / 2^quant), capped at T.
    function automatic longint unsigned quota(input longint unsigned u,
                                              input longint unsigned t,
                                              input int quant);
        longint unsigned s;
        s = (u * t + (64'd1 << (quant - 1))) >> quant;
        if (s > t) begin
            s = t;
        end
        return s;
    endfunction

    // The stream must split into whole chunks.
    function automatic bit lanes_ok(input int t, input int lanes);
        return (t > 0) && (lanes > 0) && ((t % lanes) == 0);
    endfunction

    // The Weyl step must be coprime with the stream length to be a permutation.
    function automatic bit stride_ok(input int stride, input int t);
        return (t > 0) && (gcd(stride, t) == 1);
    endfunction

endpackage

// File: rtl/sng_quota.sv
// Converts one signed sample into its bitstream quota s (number of ones).
module sng_quota
    import sng_pkg::*;
#(
    parameter int QUANT     = 8,
    parameter int BITSTREAM = 64,
    parameter int SW        = 7
) (
    input  logic [QUANT-1:0] iSample,
    output logic [SW-1:0]    oQuota
);

    logic [QUANT-1:0] sample_u;

    // Adding 2^(QUANT-1) to a two's complement value is just an MSB flip.
    assign sample_u = iSample ^ {1'b1, {(QUANT-1){1'b0}}};

    // BITSTREAM is a constant, so the product reduces to shifts and adds.
    assign oQuota = SW'(quota(64'(sample_u), 64'(BITSTREAM), QUANT));

endmodule

// File: rtl/sng_stream.sv
// Multi-channel stochastic bitstream generator. Each accepted sample vector
// becomes one T-bit stream per channel, emitted LANES bits per cycle. Bit
// positions are filled in Weyl order, so bit p is set when its visit rank is
// below the channel's quota; ranks are elaboration-time constants.
module sng_stream
    import sng_pkg::*;
#(
    parameter int BITSTREAM    = 64,
    parameter int QUANT        = 8,
    parameter int CHANNELS     = 4,
    parameter int LANES        = 8,
    parameter int BASE         = 2,
    parameter int STRIDE       = 17,
    parameter int CH_BASE_STEP = 0
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic [CHANNELS*QUANT-1:0] iData,
    input  logic                      iValid,
    output logic                      oReady,
    output logic [CHANNELS*LANES-1:0] oChunk,
    output logic                      oValid,
    input  logic                      iReady,
    output logic                      oLast
);

    localparam int NCHUNK = BITSTREAM / LANES;
    localparam int SW     = $clog2(BITSTREAM) + 1;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    // Refuse to build with a stream that does not split into whole chunks
    // or a step that would not visit every position.
    if (!lanes_ok(BITSTREAM, LANES)) begin : g_bad_lanes
        $error("sng_stream: BITSTREAM must be a positive multiple of LANES");
    end
    if (!stride_ok(STRIDE, BITSTREAM)) begin : g_bad_stride
        $error("sng_stream: STRIDE must be coprime with BITSTREAM");
    end

    state_t          state_q;
    state_t          state_d;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   k_d;
    logic [SW-1:0]   s_q     [CHANNELS];
    logic [SW-1:0]   quota_w [CHANNELS];
    logic            accept;

    // Handshake outputs depend only on registered state (plus iReady for the
    // zero-bubble reload on the final chunk).
    always_comb begin
        oValid = 1'b0;
        oLast  = 1'b0;
        oReady = 1'b1;
        if (state_q == STREAM) begin
            oValid = 1'b1;
            oLast  = (k_q == K_LAST);
            oReady = oLast && iReady;
        end
    end

    assign accept = iValid && oReady;

    // Next state and chunk counter.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (iValid) begin
                    state_d = STREAM;
                    k_d     = '0;
                end
            end
            STREAM: begin
                if (iReady) begin
                    if (oLast) begin
                        k_d     = '0;
                        state_d = iValid ? STREAM : IDLE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    // State and chunk counter registers.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Capture every channel's quota when a vector is accepted.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                s_q[c] <= '0;
            end
        end else if (accept) begin
            for (int c = 0; c < CHANNELS; c++) begin
                s_q[c] <= quota_w[c];
            end
        end
    end

    genvar gi;
    genvar gk;
    genvar gj;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [LANES-1:0] chunks [NCHUNK];

            sng_quota #(
                .QUANT     (QUANT),
                .BITSTREAM (BITSTREAM),
                .SW        (SW)
            ) u_quota (
                .iSample (iData[gi*QUANT +: QUANT]),
                .oQuota  (quota_w[gi])
            );

            // Each bit is a compare of the registered quota with a constant rank.
            for (gk = 0; gk < NCHUNK; gk++) begin : g_chunk
                for (gj = 0; gj < LANES; gj++) begin : g_lane
                    localparam logic [SW-1:0] RANK = SW'(rank(gk * LANES + gj,
                        ch_start(gi, BASE, CH_BASE_STEP, BITSTREAM), STRIDE, BITSTREAM));
                    assign chunks[gk][gj] = (RANK < s_q[gi]);
                end
            end

            // Chunks are silent outside a stream.
            assign oChunk[gi*LANES +: LANES] = (state_q == STREAM) ? chunks[k_q] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_sng_stream.sv
// Self-checking bench for sng_stream at default parameters. The reference
// model builds each channel's stream by walking the Weyl sequence and setting
// the first s positions it visits.
module tb_sng_stream;

    localparam int T      = 64;
    localparam int Q      = 8;
    localparam int CH     = 4;
    localparam int L      = 8;
    localparam int BASE   = 2;
    localparam int STRIDE = 17;
    localparam int CBS    = 0;
    localparam int NCH    = T / L;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH*Q-1:0]   data;
    logic              in_valid;
    logic              out_ready;
    logic [CH*L-1:0]   chunk;
    logic              out_valid;
    logic              in_ready;
    logic              last;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sng_stream #(
        .BITSTREAM    (T),
        .QUANT        (Q),
        .CHANNELS     (CH),
        .LANES        (L),
        .BASE         (BASE),
        .STRIDE       (STRIDE),
        .CH_BASE_STEP (CBS)
    ) dut (
        .iClk   (clk),
        .iRst   (rst),
        .iData  (data),
        .iValid (in_valid),
        .oReady (out_ready),
        .oChunk (chunk),
        .oValid (out_valid),
        .iReady (in_ready),
        .oLast  (last)
    );

    // ---------------- reference model ----------------
    function automatic int m_quota(input logic [Q-1:0] q);
        int u;
        int s;
        u = int'($signed(q)) + (1 << (Q - 1));
        s = (u * T + (1 << (Q - 1))) / (1 << Q);
        if (s > T) s = T;
        return s;
    endfunction

    function automatic logic [T-1:0] m_stream(input int s, input int c);
        logic [T-1:0] b;
        int pos;
        b   = '0;
        pos = (BASE + c * CBS) % T;
        for (int r = 0; r < s; r++) begin
            b[pos] = 1'b1;
            pos = (pos + STRIDE) % T;
        end
        return b;
    endfunction

    function automatic logic [CH*L-1:0] m_chunk(input logic [CH*Q-1:0] d, input int k);
        logic [CH*L-1:0] o;
        logic [T-1:0]    b;
        o = '0;
        for (int c = 0; c < CH; c++) begin
            b = m_stream(m_quota(d[c*Q +: Q]), c);
            o[c*L +: L] = b[k*L +: L];
        end
        return o;
    endfunction

    // Present a vector for exactly one clock edge (accepted from IDLE).
    task automatic accept(input logic [CH*Q-1:0] d);
        @(negedge clk);
        data     = d;
        in_valid = 1'b1;
        in_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        data     = $urandom;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_ready = 1'b0; data = '0;
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", last); end
        total++; if (chunk !== '0) begin bad++; $display("FAIL reset_chunk got=%h want=0", chunk); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (out_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", out_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid got=%b want=0", out_valid); end
        $display("reset: checked idle outputs");
    endtask

    // One full stream without backpressure; iData is scrambled mid-stream and
    // iValid toggled on non-final chunks, which must have no effect.
    task automatic test_stream(input string name, input logic [CH*Q-1:0] d,
                               output logic [CH*T-1:0] cap);
        logic [CH*L-1:0] exp;
        cap = '0;
        total++; if (out_ready !== 1'b1) begin bad++; $display("FAIL %s ready_before got=%b want=1", name, out_ready); end
        accept(d);
        for (int k = 0; k < NCH; k++) begin
            exp = m_chunk(d, k);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s valid k=%0d got=%b want=1", name, k, out_valid); end
            total++; if (last !== (k == NCH - 1)) begin bad++; $display("FAIL %s last k=%0d got=%b want=%b", name, k, last, (k == NCH - 1)); end
            total++; if (chunk !== exp) begin bad++; $display("FAIL %s chunk k=%0d got=%h want=%h", name, k, chunk, exp); end
            for (int c = 0; c < CH; c++) cap[c*T + k*L +: L] = chunk[c*L +: L];
            data     = $urandom;
            in_valid = (k < NCH - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s valid_after got=%b want=0", name, out_valid); end
        total++; if (out_ready !== 1'b1) begin bad++; $display("FAIL %s ready_after got=%b want=1", name, out_ready); end
        $display("stream %s: data=%h chunks=%0d", name, d, NCH);
    endtask

    task automatic test_min();
        logic [CH*T-1:0] cap;
        test_stream("min", {CH{8'h80}}, cap);
        total++; if (cap !== '0) begin bad++; $display("FAIL min_all_zero got=%h want=0", cap); end
    endtask

    task automatic test_max();
        logic [CH*T-1:0] cap;
        test_stream("max", {CH{8'h7F}}, cap);
        total++; if (cap !== {(CH*T){1'b1}}) begin bad++; $display("FAIL max_all_ones got=%h want=all ones", cap); end
    endtask

    task automatic test_mid();
        logic [CH*T-1:0] cap;
        test_stream("mid", {CH{8'h00}}, cap);
        for (int c = 0; c < CH; c++) begin
            total++; if ($countones(cap[c*T +: T]) != 32) begin bad++; $display("FAIL mid_popcount ch=%0d got=%0d want=32", c, $countones(cap[c*T +: T])); end
            total++; if (cap[c*T + 2] !== 1'b1) begin bad++; $display("FAIL mid_bit2 ch=%0d got=%b want=1", c, cap[c*T + 2]); end
            total++; if (cap[c*T + 19] !== 1'b1) begin bad++; $display("FAIL mid_bit19 ch=%0d got=%b want=1", c, cap[c*T + 19]); end
            total++; if (cap[c*T + 34] !== 1'b0) begin bad++; $display("FAIL mid_bit34 ch=%0d got=%b want=0", c, cap[c*T + 34]); end
        end
    endtask

    task automatic test_random();
        logic [CH*T-1:0] cap;
        for (int n = 0; n < 6; n++) begin
            test_stream("random", $urandom, cap);
        end
    endtask

    // Stall three cycles while chunk 3 is presented.
    task automatic test_backpressure();
        logic [CH*Q-1:0] d;
        logic [CH*L-1:0] exp;
        int k;
        int stall;
        bit done;
        d = 32'h05D03AE7;
        k = 0; stall = 0; done = 1'b0;
        accept(d);
        for (int cyc = 0; cyc < 4 * NCH && !done; cyc++) begin
            in_ready = !(k == 3 && stall < 3);
            exp = m_chunk(d, k);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp valid k=%0d got=%b want=1", k, out_valid); end
            total++; if (chunk !== exp) begin bad++; $display("FAIL bp chunk k=%0d stall=%0d got=%h want=%h", k, stall, chunk, exp); end
            total++; if (last !== (k == NCH - 1)) begin bad++; $display("FAIL bp last k=%0d got=%b want=%b", k, last, (k == NCH - 1)); end
            if (in_ready) begin
                if (k == NCH - 1) done = 1'b1;
                k++;
            end else begin
                stall++;
            end
            @(negedge clk);
        end
        in_ready = 1'b1;
        total++; if (!done) begin bad++; $display("FAIL bp_complete got=incomplete want=complete"); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp valid_after got=%b want=0", out_valid); end
        $display("backpressure: data=%h stalls=%0d", d, stall);
    endtask

    // iValid held high: second vector taken on the last-chunk handshake.
    task automatic test_back_to_back();
        logic [CH*Q-1:0] d1;
        logic [CH*Q-1:0] d2;
        logic [CH*L-1:0] exp;
        d1 = $urandom;
        d2 = $urandom;
        accept(d1);
        data = d2; in_valid = 1'b1;
        #1;
        total++; if (out_ready !== 1'b0) begin bad++; $display("FAIL b2b ready_mid got=%b want=0", out_ready); end
        for (int k = 0; k < NCH; k++) begin
            exp = m_chunk(d1, k);
            total++; if (chunk !== exp) begin bad++; $display("FAIL b2b chunk1 k=%0d got=%h want=%h", k, chunk, exp); end
            if (k == NCH - 1) begin
                total++; if (out_ready !== 1'b1) begin bad++; $display("FAIL b2b ready_last got=%b want=1", out_ready); end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        data = $urandom;
        for (int k = 0; k < NCH; k++) begin
            exp = m_chunk(d2, k);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b valid2 k=%0d got=%b want=1", k, out_valid); end
            total++; if (chunk !== exp) begin bad++; $display("FAIL b2b chunk2 k=%0d got=%h want=%h", k, chunk, exp); end
            @(negedge clk);
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b valid_after got=%b want=0", out_valid); end
        $display("back_to_back: d1=%h d2=%h", d1, d2);
    endtask

    // Reset pulsed while chunk 5 is presented.
    task automatic test_reset_mid();
        logic [CH*Q-1:0] d;
        logic [CH*L-1:0] exp;
        d = {CH{8'h7F}};
        accept(d);
        repeat (5) @(negedge clk);
        exp = m_chunk(d, 5);
        total++; if (chunk !== exp) begin bad++; $display("FAIL rmid chunk5 got=%h want=%h", chunk, exp); end
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid valid got=%b want=0", out_valid); end
        total++; if (chunk !== '0) begin bad++; $display("FAIL rmid chunk got=%h want=0", chunk); end
        total++; if (last !== 1'b0) begin bad++; $display("FAIL rmid last got=%b want=0", last); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (out_ready !== 1'b1) begin bad++; $display("FAIL rmid ready got=%b want=1", out_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid no_partial i=%0d got=%b want=0", i, out_valid); end
        end
        $display("reset_mid: data=%h reset at chunk 5", d);
    endtask

    initial begin
        logic [CH*T-1:0] cap;
        test_reset();
        test_min();
        test_max();
        test_mid();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_stream("recover", $urandom, cap);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
